multicycle_ctrl: RTL and testbench

//  Multi-cycle sequencer for the 4-bit-opcode CPU datapath (regfile, ALU, shared instr/data memory).

---
 rtl/multicycle_ctrl.sv | 89 ++++++++
 tb/tb_multicycle_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer with shared memory-port handshake and timeout fault
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             halt,
  input  logic [3:0]       ir_op,
  input  logic             zero,
  input  logic             lt,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             alu_src,
  output logic             mem_to_reg,
  output logic [3:0]       alucontrol,
  output logic             busy,
  output logic             fault,
  output logic [CNT_W-1:0] retire_cnt
);
  localparam int TW = MEM_TIMEOUT > 0 ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [3:0] LDUR = 4'd1, STUR = 4'd2, BL = 4'd4, BEQ = 4'd6, BLT = 4'd7;
  typedef enum logic [3:0] {IDLE, FETCH, DECODE, EXEC, MEM_RD, MEM_WR, WB, BRANCH, FAULT} state_t;
  state_t state, next;
  logic [3:0] op;
  logic tk, retire, hs, stall, tmo, in_alu;
  logic [TW-1:0] wcnt;
  always_comb begin
    mem_req = state inside {FETCH, MEM_RD, MEM_WR};
    mem_we = state == MEM_WR;
    hs = mem_req && mem_ready;
    stall = mem_req && !mem_ready;
    tmo = MEM_TIMEOUT != 0 && stall && wcnt == TW'(MEM_TIMEOUT - 1);
    retire = state inside {WB, BRANCH} || (state == MEM_WR && mem_ready);
    ir_write = state == FETCH && mem_ready;
    pc_write = ir_write || state == BRANCH;
    pc_src = state == BRANCH && (op == BL || tk);
    reg_dst = state == BRANCH && op == BL;
    reg_write = state == WB || reg_dst;
    alu_src = state inside {EXEC, MEM_RD, MEM_WR, WB} && op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd5};
    mem_to_reg = state == WB && op == LDUR;
    in_alu = state inside {EXEC, MEM_RD, MEM_WR};
    alucontrol = !in_alu ? 4'd0
               : op inside {4'd0, 4'd6, 4'd7, 4'd9} ? 4'd2
               : op inside {4'd1, 4'd2, 4'd3, 4'd8} ? 4'd1
               : op == 4'd10 ? 4'd3
               : op == 4'd11 ? 4'd4
               : op inside {4'd5, 4'd12} ? 4'd5
               : op == 4'd13 ? 4'd6
               : op == 4'd15 ? 4'd7
               : op == 4'd14 ? 4'd8 : 4'd0;
    busy = !(state inside {IDLE, FAULT});
    fault = state == FAULT;
    next = state;
    if (tmo) next = FAULT;
    else if (retire) next = halt ? IDLE : FETCH;
    else
      case (state)
        IDLE:    next = run ? FETCH : IDLE;
        FETCH:   next = mem_ready ? DECODE : FETCH;
        DECODE:  next = EXEC;
        EXEC:    next = op == LDUR ? MEM_RD : op == STUR ? MEM_WR : op inside {BL, BEQ, BLT} ? BRANCH : WB;
        MEM_RD:  next = mem_ready ? WB : MEM_RD;
        default: next = state;
      endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      op <= '0;
      tk <= 1'b0;
      wcnt <= '0;
      retire_cnt <= '0;
    end else begin
      state <= next;
      if (state == DECODE) op <= ir_op;
      if (state == EXEC) tk <= (op == BEQ && zero) || (op == BLT && lt);
      if (stall) wcnt <= wcnt + TW'(1);
      else if (hs) wcnt <= '0;
      if (retire) retire_cnt <= retire_cnt + CNT_W'(1);
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard bench; stimulus queues per-cycle strobe vectors, a monitor checks every busy cycle
module tb_multicycle_ctrl;
  logic clk = 0, reset = 1, run = 0, halt = 0, zero = 0, lt = 0, mem_ready = 0;
  logic [3:0] ir_op = '0;
  logic mem_req, mem_we, ir_write, pc_write, pc_src, reg_write, reg_dst, alu_src, mem_to_reg, busy, fault;
  logic [3:0] alucontrol;
  logic [7:0] retire_cnt;
  logic [12:0] q[$];
  int n_chk = 0, n_fail = 0;

  multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .run(run), .halt(halt), .ir_op(ir_op), .zero(zero), .lt(lt),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write), .reg_dst(reg_dst),
    .alu_src(alu_src), .mem_to_reg(mem_to_reg), .alucontrol(alucontrol), .busy(busy),
    .fault(fault), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] act();
    return {mem_req, mem_we, ir_write, pc_write, pc_src, reg_write, reg_dst, alu_src, mem_to_reg, alucontrol};
  endfunction

  function automatic logic [12:0] ev(input bit rq, we, irw, pcw, pcs, rw, rd, as, m2r, input logic [3:0] alu);
    return {rq, we, irw, pcw, pcs, rw, rd, as, m2r, alu};
  endfunction

  function automatic logic [3:0] exp_alu(input logic [3:0] o);
    case (o)
      4'd0, 4'd6, 4'd7, 4'd9: return 4'd2;
      4'd1, 4'd2, 4'd3, 4'd8: return 4'd1;
      4'd10: return 4'd3;
      4'd11: return 4'd4;
      4'd5, 4'd12: return 4'd5;
      4'd13: return 4'd6;
      4'd15: return 4'd7;
      4'd14: return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    run = 1;
    tick();
    run = 0;
  endtask

  // Called with the DUT sitting in FETCH; leaves it in FETCH (or IDLE when h=1) after retire.
  task automatic instr(input logic [3:0] o, input int fw, input int mw, input bit z, input bit l, input bit h);
    bit a = o inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd5};
    bit tkn = o == 4'd4 || (o == 4'd6 && z) || (o == 4'd7 && l);
    logic [3:0] al = exp_alu(o);
    halt = h;
    repeat (fw) q.push_back(ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0));
    q.push_back(ev(1, 0, 1, 1, 0, 0, 0, 0, 0, 4'd0));
    q.push_back('0);
    q.push_back(ev(0, 0, 0, 0, 0, 0, 0, a, 0, al));
    if (o == 4'd1) begin
      repeat (mw + 1) q.push_back(ev(1, 0, 0, 0, 0, 0, 0, 1, 0, al));
      q.push_back(ev(0, 0, 0, 0, 0, 1, 0, 1, 1, 4'd0));
    end else if (o == 4'd2)
      repeat (mw + 1) q.push_back(ev(1, 1, 0, 0, 0, 0, 0, 1, 0, al));
    else if (o inside {4'd4, 4'd6, 4'd7})
      q.push_back(ev(0, 0, 0, 1, tkn, o == 4'd4, o == 4'd4, 0, 0, 4'd0));
    else
      q.push_back(ev(0, 0, 0, 0, 0, 1, 0, a, 0, 4'd0));
    mem_ready = 0;
    repeat (fw) tick();
    mem_ready = 1;
    ir_op = o;
    tick();
    tick();
    mem_ready = 0;
    ir_op = 4'($urandom);
    zero = z;
    lt = l;
    tick();
    zero = !z;
    lt = !l;
    if (o == 4'd1 || o == 4'd2) begin
      repeat (mw) tick();
      mem_ready = 1;
      tick();
      mem_ready = 0;
      if (o == 4'd1) tick();
    end else tick();
    halt = 0;
  endtask

  initial forever begin
    @(negedge clk);
    if (busy) begin
      if (q.size() == 0) chk("unexpected_busy_cycle", 32'(act()), 32'h1fff_ffff);
      else chk("cycle_strobes", 32'(act()), 32'(q.pop_front()));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) tick();
    chk("reset_strobes", 32'(act()), 0);
    chk("reset_busy_fault", {busy, fault}, 0);
    chk("reset_retire_cnt", retire_cnt, 0);
    reset = 0;
    tick();
    chk("idle_no_run", busy, 0);
    start();
    instr(4'd8, 0, 0, 0, 0, 0);
    chk("add_retire_cnt", retire_cnt, 1);
    instr(4'd1, 1, 3, 0, 0, 0);
    instr(4'd6, 0, 0, 1, 0, 0);
    instr(4'd6, 0, 0, 0, 1, 0);
    instr(4'd7, 0, 0, 0, 1, 0);
    instr(4'd2, 0, 2, 0, 0, 0);
    instr(4'd15, 2, 0, 0, 0, 0);
    instr(4'd11, 0, 0, 0, 0, 0);
    instr(4'd0, 0, 0, 0, 0, 0);
    instr(4'd4, 0, 0, 0, 0, 1);
    chk("halt_busy", busy, 0);
    chk("halt_retire_cnt", retire_cnt, 10);
    repeat (3) tick();
    start();
    mem_ready = 0;
    repeat (4) q.push_back(ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0));
    repeat (4) tick();
    chk("timeout_fault", fault, 1);
    chk("timeout_busy_req", {busy, mem_req}, 0);
    run = 1;
    repeat (2) tick();
    run = 0;
    chk("fault_sticky", fault, 1);
    reset = 1;
    #1;
    chk("reset_clears_fault", fault, 0);
    tick();
    reset = 0;
    start();
    repeat (255) instr(4'd14, 0, 0, 0, 0, 0);
    chk("cnt_at_max", retire_cnt, 8'hff);
    instr(4'd14, 0, 0, 0, 0, 0);
    chk("cnt_wrap", retire_cnt, 0);
    q.push_back(ev(1, 0, 1, 1, 0, 0, 0, 0, 0, 4'd0));
    q.push_back('0);
    q.push_back(ev(0, 0, 0, 0, 0, 0, 0, 1, 0, 4'd1));
    q.push_back(ev(1, 1, 0, 0, 0, 0, 0, 1, 0, 4'd1));
    mem_ready = 1;
    ir_op = 4'd2;
    tick();
    tick();
    mem_ready = 0;
    tick();
    @(negedge clk);
    #1;
    chk("stur_req_before_reset", {mem_req, mem_we}, 2'b11);
    reset = 1;
    #1;
    chk("reset_drops_req", {mem_req, mem_we}, 0);
    chk("reset_no_partial_retire", retire_cnt, 0);
    tick();
    reset = 0;
    repeat (2) tick();
    chk("scoreboard_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
